// File: rtl/hv_mem_arbiter.sv
// hv_mem_arbiter: shares one single-port synchronous memory between the hvcore fetch and data ports.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_en_i, instr_addr_i    fetch request (level, held until instr_valid_o) and address
//   instr_o, instr_valid_o     fetched word (held until the next fetch capture) and 1-cycle done pulse
//   dmem_en_i, dmem_wr_i       data request (level, held until dmem_rdata_valid_o) and write select
//   dmem_addr_i, dmem_wdata_i  data address and write data
//   dmem_rdata_o               read data (held until the next data-read capture)
//   dmem_rdata_valid_o         1-cycle completion pulse (acknowledge for writes)
//   mem_en_o, mem_wr_o         memory access strobe (1 cycle per access) and write enable
//   mem_addr_o, mem_wdata_o    memory address and write data
//   mem_rdata_i                memory read data, valid RD_LAT cycles after the mem_en_o cycle
module hv_mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          imem_en_i,
    input  logic [AW-1:0] instr_addr_i,
    output logic [DW-1:0] instr_o,
    output logic          instr_valid_o,
    input  logic          dmem_en_i,
    input  logic          dmem_wr_i,
    input  logic [AW-1:0] dmem_addr_i,
    input  logic [DW-1:0] dmem_wdata_i,
    output logic [DW-1:0] dmem_rdata_o,
    output logic          dmem_rdata_valid_o,
    output logic          mem_en_o,
    output logic          mem_wr_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic       GNT_I    = 1'b0;
    localparam logic       GNT_D    = 1'b1;
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_grant;
    logic          r_last;
    logic [1:0]    r_lat_cnt;
    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_drdata;
    logic          w_req;
    logic          w_gnt;
    logic          w_issue;
    logic          w_capture;

    assign w_req     = imem_en_i | dmem_en_i;
    // Under contention the port that did not win last time gets the memory.
    assign w_gnt     = (imem_en_i & dmem_en_i) ? ~r_last : dmem_en_i;
    // rst_n gates the strobe so an access request cannot leak out while reset is held.
    assign w_issue   = rst_n & (r_state == S_IDLE) & w_req;
    assign w_capture = (r_state == S_WAIT) & (r_lat_cnt == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && w_req)
            w_next = (w_gnt == GNT_D && dmem_wr_i) ? S_RESP : S_WAIT;
        else if (w_capture)
            w_next = S_RESP;
        else if (r_state == S_RESP)
            w_next = S_IDLE;
    end

    always_comb begin
        mem_en_o           = w_issue;
        mem_wr_o           = w_issue & (w_gnt == GNT_D) & dmem_wr_i;
        mem_addr_o         = !w_issue ? '0 : (w_gnt == GNT_D) ? dmem_addr_i : instr_addr_i;
        mem_wdata_o        = (w_issue && w_gnt == GNT_D) ? dmem_wdata_i : '0;
        instr_valid_o      = (r_state == S_RESP) & (r_grant == GNT_I);
        dmem_rdata_valid_o = (r_state == S_RESP) & (r_grant == GNT_D);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant   <= GNT_I;
            r_last    <= GNT_I;
            r_lat_cnt <= 2'd0;
            r_instr   <= '0;
            r_drdata  <= '0;
        end else begin
            if (w_issue) begin
                r_grant   <= w_gnt;
                r_last    <= w_gnt;
                r_lat_cnt <= LAT_INIT;
            end else if (r_state == S_WAIT && r_lat_cnt != 2'd0) begin
                r_lat_cnt <= r_lat_cnt - 2'd1;
            end
            if (w_capture && r_grant == GNT_D)
                r_drdata <= mem_rdata_i;
            if (w_capture && r_grant == GNT_I)
                r_instr <= mem_rdata_i;
        end
    end

    assign instr_o      = r_instr;
    assign dmem_rdata_o = r_drdata;

endmodule

// File: tb/tb_hv_mem_arbiter.sv
// tb_hv_mem_arbiter: directed and randomized checks of hv_mem_arbiter at RD_LAT=1 and RD_LAT=3.
module tb_hv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ien;
    logic [31:0] iaddr;
    logic        den;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] dwd;
    int          s;
    int          n_tests;
    int          n_fail;

    logic [31:0] w_instr [2];
    logic [31:0] w_drd   [2];
    logic [31:0] w_maddr [2];
    logic [31:0] w_mwd   [2];
    logic [31:0] w_mrd   [2];
    logic        w_iv    [2];
    logic        w_dv    [2];
    logic        w_men   [2];
    logic        w_mwr   [2];

    bit [31:0] sh [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gd
        localparam int L = (g == 0) ? 1 : 3;
        bit [31:0] mem  [256];
        bit [31:0] pipe [L];
        hv_mem_arbiter #(.AW(32), .DW(32), .RD_LAT(L)) u_dut (
            .clk                (clk),
            .rst_n              (rst_n),
            .imem_en_i          (ien && (s == g)),
            .instr_addr_i       (iaddr),
            .instr_o            (w_instr[g]),
            .instr_valid_o      (w_iv[g]),
            .dmem_en_i          (den && (s == g)),
            .dmem_wr_i          (dwr),
            .dmem_addr_i        (daddr),
            .dmem_wdata_i       (dwd),
            .dmem_rdata_o       (w_drd[g]),
            .dmem_rdata_valid_o (w_dv[g]),
            .mem_en_o           (w_men[g]),
            .mem_wr_o           (w_mwr[g]),
            .mem_addr_o         (w_maddr[g]),
            .mem_wdata_o        (w_mwd[g]),
            .mem_rdata_i        (w_mrd[g])
        );
        assign w_mrd[g] = pipe[L-1];
        always @(posedge clk) begin
            if (w_men[g] && w_mwr[g]) mem[w_maddr[g][9:2]] <= w_mwd[g];
            pipe[0] <= mem[w_maddr[g][9:2]];
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset(input int sel);
        s = sel;
        ien = 0; den = 0; dwr = 0; iaddr = 0; daddr = 0; dwd = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic wr_data(input logic [31:0] a, input logic [31:0] d);
        tick;
        den = 1; dwr = 1; daddr = a; dwd = d;
        settle;
        tick;
        den = 0; dwr = 0;
    endtask

    task automatic test_reset;
        s = 0;
        rst_n = 0; ien = 1; den = 1; dwr = 1; iaddr = 32'h44; daddr = 32'h88; dwd = 32'h1;
        #3;
        for (int g = 0; g < 2; g++) begin
            s = g;
            settle;
            n_tests++; if (w_men[g] !== 1'b0) begin n_fail++; $display("FAIL reset_men[%0d]: got %b want 0", g, w_men[g]); end
            n_tests++; if (w_mwr[g] !== 1'b0) begin n_fail++; $display("FAIL reset_mwr[%0d]: got %b want 0", g, w_mwr[g]); end
            n_tests++; if (w_maddr[g] !== 32'h0) begin n_fail++; $display("FAIL reset_maddr[%0d]: got %h want 0", g, w_maddr[g]); end
            n_tests++; if (w_mwd[g] !== 32'h0) begin n_fail++; $display("FAIL reset_mwd[%0d]: got %h want 0", g, w_mwd[g]); end
            n_tests++; if (w_iv[g] !== 1'b0 || w_dv[g] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b%b want 00", g, w_iv[g], w_dv[g]); end
            n_tests++; if (w_instr[g] !== 32'h0 || w_drd[g] !== 32'h0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h/%h want 0/0", g, w_instr[g], w_drd[g]); end
        end
        do_reset(0);
    endtask

    task automatic test_fetch;
        wr_data(32'h10, 32'hDEADBEEF);
        tick; ien = 1; iaddr = 32'h10; settle;
        n_tests++; if (w_men[s] !== 1'b1 || w_maddr[s] !== 32'h10 || w_mwr[s] !== 1'b0) begin n_fail++; $display("FAIL fetch_issue: got en=%b addr=%h wr=%b want 1/10/0", w_men[s], w_maddr[s], w_mwr[s]); end
        tick; settle;
        n_tests++; if (w_men[s] !== 1'b0 || w_iv[s] !== 1'b0) begin n_fail++; $display("FAIL fetch_c1: got en=%b iv=%b want 0/0", w_men[s], w_iv[s]); end
        tick; settle;
        n_tests++; if (w_iv[s] !== 1'b1 || w_instr[s] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_c2: got iv=%b instr=%h want 1/deadbeef", w_iv[s], w_instr[s]); end
        ien = 0;
        tick; settle;
        n_tests++; if (w_iv[s] !== 1'b0 || w_instr[s] !== 32'hDEADBEEF || w_men[s] !== 1'b0) begin n_fail++; $display("FAIL fetch_c3: got iv=%b instr=%h en=%b want 0/deadbeef/0", w_iv[s], w_instr[s], w_men[s]); end
    endtask

    task automatic test_write_read;
        tick; den = 1; dwr = 1; daddr = 32'h40; dwd = 32'h12345678; settle;
        n_tests++; if (w_men[s] !== 1'b1 || w_mwr[s] !== 1'b1 || w_maddr[s] !== 32'h40 || w_mwd[s] !== 32'h12345678) begin n_fail++; $display("FAIL wr_issue: got en=%b wr=%b addr=%h wd=%h", w_men[s], w_mwr[s], w_maddr[s], w_mwd[s]); end
        tick; settle;
        n_tests++; if (w_dv[s] !== 1'b1 || w_men[s] !== 1'b0) begin n_fail++; $display("FAIL wr_ack: got dv=%b en=%b want 1/0", w_dv[s], w_men[s]); end
        den = 0; dwr = 0;
        tick; den = 1; daddr = 32'h40; settle;
        n_tests++; if (w_men[s] !== 1'b1 || w_mwr[s] !== 1'b0 || w_mwd[s] !== 32'h12345678) begin n_fail++; $display("FAIL rd_issue: got en=%b wr=%b wd=%h", w_men[s], w_mwr[s], w_mwd[s]); end
        tick; settle;
        n_tests++; if (w_dv[s] !== 1'b0) begin n_fail++; $display("FAIL rd_c3: got dv=%b want 0", w_dv[s]); end
        tick; settle;
        n_tests++; if (w_dv[s] !== 1'b1 || w_drd[s] !== 32'h12345678) begin n_fail++; $display("FAIL rd_c4: got dv=%b rd=%h want 1/12345678", w_dv[s], w_drd[s]); end
        den = 0;
        tick; settle;
        n_tests++; if (w_dv[s] !== 1'b0 || w_drd[s] !== 32'h12345678) begin n_fail++; $display("FAIL rd_c5: got dv=%b rd=%h", w_dv[s], w_drd[s]); end
    endtask

    task automatic test_contention;
        logic [31:0] ea;
        do_reset(0);
        ien = 1; iaddr = 32'h100; den = 1; dwr = 0; daddr = 32'h200;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick;
            settle;
            ea = ((c / 3) % 2 == 0) ? 32'h200 : 32'h100;
            n_tests++; if (w_men[s] !== (c % 3 == 0)) begin n_fail++; $display("FAIL cont_en c%0d: got %b want %b", c, w_men[s], c % 3 == 0); end
            if (c % 3 == 0) begin
                n_tests++; if (w_maddr[s] !== ea) begin n_fail++; $display("FAIL cont_addr c%0d: got %h want %h", c, w_maddr[s], ea); end
            end
            n_tests++; if (w_iv[s] !== (c % 6 == 5) || w_dv[s] !== (c % 6 == 2)) begin n_fail++; $display("FAIL cont_valid c%0d: got iv=%b dv=%b", c, w_iv[s], w_dv[s]); end
        end
        ien = 0; den = 0;
    endtask

    task automatic test_refetch;
        wr_data(32'h14, 32'hCAFEF00D);
        tick; ien = 1; iaddr = 32'h10; settle;
        n_tests++; if (w_men[s] !== 1'b1 || w_maddr[s] !== 32'h10) begin n_fail++; $display("FAIL refetch_c0: got en=%b addr=%h", w_men[s], w_maddr[s]); end
        tick; settle;
        n_tests++; if (w_men[s] !== 1'b0) begin n_fail++; $display("FAIL refetch_c1: got en=%b want 0", w_men[s]); end
        tick; settle;
        n_tests++; if (w_iv[s] !== 1'b1 || w_men[s] !== 1'b0 || w_instr[s] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL refetch_c2: got iv=%b en=%b instr=%h", w_iv[s], w_men[s], w_instr[s]); end
        tick; iaddr = 32'h14; settle;
        n_tests++; if (w_men[s] !== 1'b1 || w_maddr[s] !== 32'h14) begin n_fail++; $display("FAIL refetch_c3: got en=%b addr=%h want 1/14", w_men[s], w_maddr[s]); end
        tick; settle;
        tick; settle;
        n_tests++; if (w_iv[s] !== 1'b1 || w_instr[s] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL refetch_c5: got iv=%b instr=%h want 1/cafef00d", w_iv[s], w_instr[s]); end
        ien = 0;
    endtask

    task automatic test_lat3;
        do_reset(1);
        wr_data(32'h20, 32'hA5A55A5A);
        tick; den = 1; dwr = 0; daddr = 32'h20; settle;
        n_tests++; if (w_men[s] !== 1'b1 || w_maddr[s] !== 32'h20) begin n_fail++; $display("FAIL lat3_issue: got en=%b addr=%h", w_men[s], w_maddr[s]); end
        for (int c = 1; c < 4; c++) begin
            tick; settle;
            n_tests++; if (w_men[s] !== 1'b0 || w_dv[s] !== 1'b0) begin n_fail++; $display("FAIL lat3_c%0d: got en=%b dv=%b want 0/0", c, w_men[s], w_dv[s]); end
        end
        tick; settle;
        n_tests++; if (w_dv[s] !== 1'b1 || w_drd[s] !== 32'hA5A55A5A) begin n_fail++; $display("FAIL lat3_c4: got dv=%b rd=%h want 1/a5a55a5a", w_dv[s], w_drd[s]); end
        den = 0;
        tick; settle;
        n_tests++; if (w_dv[s] !== 1'b0) begin n_fail++; $display("FAIL lat3_c5: got dv=%b want 0", w_dv[s]); end
    endtask

    task automatic test_reset_mid;
        do_reset(0);
        tick; ien = 1; iaddr = 32'h10; settle;
        tick; tick; settle;
        n_tests++; if (w_iv[s] !== 1'b1 || w_instr[s] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rmid_first: got iv=%b instr=%h", w_iv[s], w_instr[s]); end
        tick; iaddr = 32'h14; settle;
        tick; settle;
        #1 rst_n = 0;
        #1;
        n_tests++; if (w_men[s] !== 1'b0 || w_iv[s] !== 1'b0 || w_instr[s] !== 32'h0 || w_maddr[s] !== 32'h0) begin n_fail++; $display("FAIL rmid_async: got en=%b iv=%b instr=%h addr=%h want 0", w_men[s], w_iv[s], w_instr[s], w_maddr[s]); end
        for (int c = 0; c < 2; c++) begin
            tick; settle;
            n_tests++; if (w_men[s] !== 1'b0 || w_iv[s] !== 1'b0) begin n_fail++; $display("FAIL rmid_hold%0d: got en=%b iv=%b", c, w_men[s], w_iv[s]); end
        end
        rst_n = 1; settle;
        n_tests++; if (w_men[s] !== 1'b1 || w_maddr[s] !== 32'h14) begin n_fail++; $display("FAIL rmid_refetch: got en=%b addr=%h", w_men[s], w_maddr[s]); end
        tick; settle;
        tick; settle;
        n_tests++; if (w_iv[s] !== 1'b1 || w_instr[s] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rmid_done: got iv=%b instr=%h", w_iv[s], w_instr[s]); end
        iaddr = 32'h10; den = 1; dwr = 0; daddr = 32'h200;
        tick; settle;
        n_tests++; if (w_men[s] !== 1'b1 || w_maddr[s] !== 32'h200) begin n_fail++; $display("FAIL rmid_grant: got en=%b addr=%h want 1/200", w_men[s], w_maddr[s]); end
        ien = 0; den = 0;
    endtask

    task automatic test_random(input int sel, input logic [31:0] base, input int ncyc);
        int          lat;
        bit          pi, pd, busy, g, last, mwr, ev_i, ev_d, e_en, e_wr;
        int          done;
        logic [31:0] mdata, e_addr, e_wd, x_instr, x_drd;
        do_reset(sel);
        lat = (sel == 0) ? 1 : 3;
        pi = 0; pd = 0; busy = 0; last = 0; g = 0; mwr = 0; done = 0; mdata = 0;
        x_instr = 0; x_drd = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) tick;
            if (!pi && $urandom_range(0, 2) == 0) begin
                pi = 1; iaddr = base + 4 * $urandom_range(0, 15);
            end
            if (!pd && $urandom_range(0, 2) == 0) begin
                pd = 1; daddr = base + 4 * $urandom_range(0, 15); dwr = 1'($urandom_range(0, 1)); dwd = $urandom;
            end
            ien = pi; den = pd;
            settle;
            e_en = 0; e_wr = 0; e_addr = 0; e_wd = 0; ev_i = 0; ev_d = 0;
            if (!busy) begin
                if (pi || pd) begin
                    g = (pi && pd) ? !last : pd;
                    last = g; busy = 1; e_en = 1;
                    e_addr = g ? daddr : iaddr;
                    e_wr = g && dwr;
                    e_wd = g ? dwd : 32'h0;
                    mwr = e_wr;
                    if (e_wr) begin
                        sh[daddr[9:2]] = dwd;
                        done = c + 1;
                    end else begin
                        mdata = sh[e_addr[9:2]];
                        done = c + lat + 1;
                    end
                end
            end else if (c == done) begin
                busy = 0;
                if (g) begin ev_d = 1; if (!mwr) x_drd = mdata; end
                else begin ev_i = 1; x_instr = mdata; end
            end
            n_tests++; if (w_men[s] !== e_en || w_mwr[s] !== e_wr || w_maddr[s] !== e_addr || w_mwd[s] !== e_wd) begin n_fail++; $display("FAIL rnd%0d_mem c%0d: got en=%b wr=%b a=%h wd=%h want %b %b %h %h", sel, c, w_men[s], w_mwr[s], w_maddr[s], w_mwd[s], e_en, e_wr, e_addr, e_wd); end
            n_tests++; if (w_iv[s] !== ev_i || w_dv[s] !== ev_d) begin n_fail++; $display("FAIL rnd%0d_valid c%0d: got iv=%b dv=%b want %b %b", sel, c, w_iv[s], w_dv[s], ev_i, ev_d); end
            n_tests++; if (w_instr[s] !== x_instr || w_drd[s] !== x_drd) begin n_fail++; $display("FAIL rnd%0d_data c%0d: got %h/%h want %h/%h", sel, c, w_instr[s], w_drd[s], x_instr, x_drd); end
            if (ev_i) pi = 0;
            if (ev_d) pd = 0;
        end
        ien = 0; den = 0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        s = 0; rst_n = 1; ien = 0; den = 0; dwr = 0; iaddr = 0; daddr = 0; dwd = 0;
        test_reset;
        test_fetch;
        test_write_read;
        test_contention;
        test_refetch;
        test_lat3;
        test_reset_mid;
        test_random(0, 32'h300, 600);
        test_random(1, 32'h380, 600);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hv_mem_arbiter.md
Name: hv_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the hvcore instruction-fetch port and its data port.
- Returns per-port data and `*_valid` pulses that drive the core's `instr_valid_i` and `dmem_rdata_valid_i` handshake inputs.
- Sits between the core and the unified memory; replaces the separate ROM and data-memory hookup.
- Both ports are served one access at a time, with alternating priority when both ports contend.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles (legal range 1..4).

Ports:
- clk  in  1  system clock. One clock domain; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_en_i  in  1  fetch request (level); held until instr_valid_o.
- instr_addr_i  in  AW  fetch address; stable while imem_en_i is high.
- instr_o  out  DW  fetched instruction.
- instr_valid_o  out  1  one-cycle fetch-complete pulse.
- dmem_en_i  in  1  data request (level); held until dmem_rdata_valid_o.
- dmem_wr_i  in  1  1=write, 0=read.
- dmem_addr_i  in  AW  data address.
- dmem_wdata_i  in  DW  write data.
- dmem_rdata_o  out  DW  read data.
- dmem_rdata_valid_o  out  1  one-cycle completion pulse; for writes it is an acknowledge.
- mem_en_o  out  1  memory access strobe, 1 cycle per access.
- mem_wr_o  out  1  memory write enable.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_rdata_i  in  DW  memory read data, valid RD_LAT cycles after the mem_en_o cycle.

Behaviour:
- Reset values (async, on rst_n low):
  - state=IDLE, lat_cnt=0, last_grant=INSTR (so data wins the first contended arbitration).
  - instr_o=0, dmem_rdata_o=0; both valid outputs 0.
  - mem_en_o=0, mem_wr_o=0, mem_addr_o=0, mem_wdata_o=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If no request, all mem_* = 0.
  - Otherwise grant combinationally in this cycle:
    - only one request → that port;
    - both → the port not in last_grant.
  - Drive mem_en_o=1; mem_addr_o, mem_wr_o and mem_wdata_o come from the granted port. mem_wr_o=0 and mem_wdata_o=0 for fetches.
  - Register grant and last_grant.
  - Data write → RESP. Any read → WAIT with lat_cnt=RD_LAT-1.
- WAIT:
  - mem_en_o=0; lat_cnt decrements each cycle.
  - In the cycle with lat_cnt==0: capture mem_rdata_i into instr_o or dmem_rdata_o per grant, then → RESP.
- RESP:
  - Assert the granted port's valid for exactly 1 cycle, then → IDLE.
  - No new memory access is issued in RESP, so a request still high in this cycle is not re-served.
- Latency:
  - Read issued in IDLE at cycle N → valid at N+RD_LAT+1.
  - Write issued at N → memory written at N's edge, ack at N+1.
- Occupancy: a read holds the arbiter for RD_LAT+2 cycles; a write for 2 cycles.
- Data outputs hold their last captured value until the next capture for the same port.
- The non-granted port's output and valid are untouched.
- A requester that drops its en before valid is a protocol violation. The arbiter still completes the access and pulses valid; no assertion is raised.
- Reset mid-operation returns to IDLE immediately. The in-flight read is discarded, no valid is pulsed, and mem_en_o drops asynchronously.
- Contention produces strict alternation, bounding the wait of either port to one foreign access.

Test Plan:
1. RD_LAT=1, mem[0x10]=0xDEADBEEF, imem_en_i=1, addr 0x10 at cycle 0 → mem_en_o=1 at cycle 0; instr_o=0xDEADBEEF with instr_valid_o=1 at cycle 2 only.
2. Data write 0x12345678 to 0x40 at cycle 0 → mem_wr_o=1 at cycle 0, dmem_rdata_valid_o at cycle 1. A following read of 0x40 issued at cycle 2 returns 0x12345678 at cycle 4.
3. Both ports request continuously from reset → grants ordered D,I,D,I; each port gets one valid per 6 cycles at RD_LAT=1.
4. Fetch held high through valid with the address changed to 0x14 at cycle 3 → second fetch issued at cycle 3 with mem_addr_o=0x14; no duplicate access to 0x10.
5. RD_LAT=3, data read 0x20 at cycle 0 → dmem_rdata_valid_o at cycle 4; mem_en_o high only in cycle 0.
6. rst_n asserted during WAIT of a fetch → outputs 0 immediately, no instr_valid_o. After release, a fresh fetch completes normally and the first contended grant goes to data.
